// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit for the E stage (radix-2 shift-add / restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divides stay iterative.
module muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MulDivStartE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic [XLEN-1:0] MulDivResultE,
    output logic            MulDivDoneE,
    output logic            multiInstrStall
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_next;
    logic [5:0]        count;
    logic [2*XLEN-1:0] acc, acc_next, acc_neg;
    logic [XLEN-1:0]   operand, result_q, final_val, special_val;
    logic [2:0]        funct;
    logic              neg;

    logic              signed_a, signed_b, sa, sb, neg_start;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN:0]     mul_sum, trial, diff;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_val;

    // Operand conditioning at issue: magnitudes plus the sign the final result must carry.
    always_comb begin
        signed_a    = (Funct3E == 3'b001) || (Funct3E == 3'b010) ||
                      (Funct3E == 3'b100) || (Funct3E == 3'b110);
        signed_b    = (Funct3E == 3'b001) || (Funct3E == 3'b100) || (Funct3E == 3'b110);
        sa          = signed_a && SrcAE[XLEN-1];
        sb          = signed_b && SrcBE[XLEN-1];
        mag_a       = sa ? -SrcAE : SrcAE;
        mag_b       = sb ? -SrcBE : SrcBE;
        neg_start   = (Funct3E == 3'b110) ? sa : (sa ^ sb);
        div_zero    = Funct3E[2] && (SrcBE == '0);
        div_ovf     = (Funct3E == 3'b100 || Funct3E == 3'b110) &&
                      (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
        special     = div_zero || div_ovf;
        special_val = '0;
        if (div_zero)
            special_val = Funct3E[1] ? SrcAE : '1;
        else if (div_ovf)
            special_val = Funct3E[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic        [2*XLEN-1:0] fast_prod;
    always_comb begin
        fast_hit  = MulDivStartE && !Funct3E[2] && (state == IDLE);
        fast_a    = {signed_a && SrcAE[XLEN-1], SrcAE};
        fast_b    = {signed_b && SrcBE[XLEN-1], SrcBE};
        fast_prod = (2*XLEN)'(fast_a * fast_b);
        fast_val  = (Funct3E[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    assign fast_hit = 1'b0;
    assign fast_val = '0;
`endif

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        trial    = acc[2*XLEN-1:XLEN-1];
        diff     = trial - {1'b0, operand};
        div_next = diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        acc_next = funct[2] ? div_next : mul_next;
        acc_neg  = -acc_next;
        case (funct)
            3'b000:                 final_val = acc_next[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_val = neg ? acc_neg[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_val = neg ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
            default:                final_val = neg ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next      = state;
        multiInstrStall = 1'b0;
        MulDivDoneE     = 1'b0;
        case (state)
            IDLE: begin
                multiInstrStall = MulDivStartE;
                if (MulDivStartE) begin
                    if (fast_hit) begin
                        multiInstrStall = 1'b0;
                        MulDivDoneE     = 1'b1;
                    end else if (special) begin
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                multiInstrStall = 1'b1;
                if (count == 6'(XLEN-1)) state_next = DONE;
            end
            DONE: begin
                MulDivDoneE = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            operand  <= '0;
            funct    <= '0;
            neg      <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (MulDivStartE && !fast_hit) begin
                    funct <= Funct3E;
                    neg   <= neg_start;
                    count <= '0;
                    if (special) begin
                        result_q <= special_val;
                    end else if (Funct3E[2]) begin
                        acc     <= {{XLEN{1'b0}}, mag_a};
                        operand <= mag_b;
                    end else begin
                        acc     <= {{XLEN{1'b0}}, mag_b};
                        operand <= mag_a;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count + 6'd1;
                    if (count == 6'(XLEN-1)) result_q <= final_val;
                end
                default: ;
            endcase
        end
    end

    assign MulDivResultE = fast_hit ? fast_val : result_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed self-checking bench for muldiv (default build, iterative multiply).
module tb_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        MulDivStartE;
    logic [2:0]  Funct3E;
    logic [31:0] SrcAE, SrcBE;
    logic [31:0] MulDivResultE;
    logic        MulDivDoneE;
    logic        multiInstrStall;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int doneA, doneB;

    muldiv #(.XLEN(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .MulDivStartE    (MulDivStartE),
        .Funct3E         (Funct3E),
        .SrcAE           (SrcAE),
        .SrcBE           (SrcBE),
        .MulDivResultE   (MulDivResultE),
        .MulDivDoneE     (MulDivDoneE),
        .multiInstrStall (multiInstrStall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        MulDivStartE = 1'b1;
        Funct3E      = f3;
        SrcAE        = a;
        SrcBE        = b;
    endtask

    // Issues one op, scrambles the forwarded operands after issue, and checks the DONE cycle.
    task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input int expOcc,
                         output int doneCyc);
        int occ;
        int stalls;
        occ    = 1;
        stalls = 0;
        applyStimulus(f3, a, b);
        #1;
        while (!MulDivDoneE && occ < 100) begin
            if (multiInstrStall) stalls++;
            @(negedge clk);
            SrcAE = ~a;
            SrcBE = ~b;
            #1;
            occ++;
        end
        doneCyc = cyc;
        checkOutput({tag, " done"}, 64'(MulDivDoneE), 64'd1);
        checkOutput({tag, " result"}, 64'(MulDivResultE), 64'(expRes));
        checkOutput({tag, " occupancy"}, 64'(occ), 64'(expOcc));
        checkOutput({tag, " stall cycles"}, 64'(stalls), 64'(expOcc - 1));
        checkOutput({tag, " stall in done"}, 64'(multiInstrStall), 64'd0);
    endtask

    task automatic idleCycle();
        MulDivStartE = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("idle stall", 64'(multiInstrStall), 64'd0);
        checkOutput("idle done", 64'(MulDivDoneE), 64'd0);
    endtask

    initial begin
        int dummy;
        $display("[TB] muldiv directed test start");
        reset        = 1'b1;
        MulDivStartE = 1'b0;
        Funct3E      = 3'b000;
        SrcAE        = '0;
        SrcBE        = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset result", 64'(MulDivResultE), 64'd0);
        checkOutput("reset done", 64'(MulDivDoneE), 64'd0);
        checkOutput("reset stall", 64'(multiInstrStall), 64'd0);
        reset = 1'b0;

        runOp("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, dummy);
        idleCycle();
        runOp("MULHU -1*-1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, dummy);
        idleCycle();
        runOp("MULH -1*-1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, dummy);
        idleCycle();
        runOp("MULHSU -1*2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, dummy);
        idleCycle();
        runOp("DIV by 0", 3'b100, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 2, dummy);
        idleCycle();
        runOp("REMU by 0", 3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678, 2, dummy);
        idleCycle();
        runOp("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, dummy);
        idleCycle();
        runOp("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, dummy);
        idleCycle();
        runOp("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, dummy);
        idleCycle();
        runOp("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, dummy);
        idleCycle();
        runOp("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 34, dummy);
        idleCycle();
        runOp("DIVU max/3", 3'b101, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34, dummy);
        idleCycle();

        // Reset while BUSY with the counter at 10.
        applyStimulus(3'b101, 32'd1000, 32'd7);
        repeat (11) @(negedge clk);
        #1;
        checkOutput("mid-busy stall", 64'(multiInstrStall), 64'd1);
        reset        = 1'b1;
        MulDivStartE = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post-reset stall", 64'(multiInstrStall), 64'd0);
        checkOutput("post-reset result", 64'(MulDivResultE), 64'd0);
        checkOutput("post-reset done", 64'(MulDivDoneE), 64'd0);
        runOp("DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 34, dummy);
        idleCycle();

        // Back-to-back: start stays high through the first DONE cycle.
        runOp("MUL 3*5", 3'b000, 32'd3, 32'd5, 32'd15, 34, doneA);
        runOp("REMU 17/5", 3'b111, 32'd17, 32'd5, 32'd2, 34, doneB);
        checkOutput("back-to-back spacing", 64'(doneB - doneA), 64'd34);
        idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
